// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc_asap memory arbiter.
//
// t_arb_id     : identifies the requester owning a grant / response.
// STARVE_CNT_W : width of the Ext starvation counter.
package rvc_asap_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        CORE = 1'b0,
        EXT  = 1'b1
    } t_arb_id;

endpackage

// File: rtl/rvc_arb_starve.sv
// Starvation tracker for the Ext requester.
//
// Counts consecutive cycles where Ext is waiting and Core wins the memory.
// Once the count reaches STARVE_MAX while Ext is still asking, forceExt
// overrides the default Core-first priority for that cycle.
//
// Ports:
//   Clock     : clock, rising edge
//   Rst       : asynchronous active-low reset
//   extValid  : Ext request pending
//   extGrant  : Ext granted this cycle
//   coreGrant : Core granted this cycle
//   forceExt  : Ext must win this cycle
`ifndef RVC_ASAP_MACROS_SV
`include "rvc_asap_macros.sv"
`endif

module rvc_arb_starve
    import rvc_asap_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic Clock,
    input  logic Rst,
    input  logic extValid,
    input  logic extGrant,
    input  logic coreGrant,
    output logic forceExt
);

    localparam logic [STARVE_CNT_W-1:0] StarveMaxC = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starveCnt;
    logic [STARVE_CNT_W-1:0] starveCntNxt;

    // The count only means "consecutive losses": any gap in Ext's request or
    // any Ext win starts it over. It cannot pass StarveMaxC because reaching
    // it forces an Ext grant, which clears it.
    always_comb begin
        starveCntNxt = starveCnt;
        if (!extValid || extGrant) begin
            starveCntNxt = '0;
        end else if (coreGrant) begin
            starveCntNxt = starveCnt + STARVE_CNT_W'(1);
        end
    end

    `RVC_DFF_RST(starveCnt, starveCntNxt, '0, Clock, Rst)

    assign forceExt = extValid && (starveCnt == StarveMaxC);

endmodule

// File: rtl/rvc_asap_macros.sv
// Shared flop macros for the rvc_asap codebase.
//
// RVC_DFF_RST    : asynchronous active-low reset flop, loads d every cycle.
// RVC_DFF_RST_EN : asynchronous active-low reset flop, loads d only when en=1.
// Arguments: q (state), d (next value), [en], rstVal, clk, rstN.
`ifndef RVC_ASAP_MACROS_SV
`define RVC_ASAP_MACROS_SV

`define RVC_DFF_RST(q, d, rstVal, clk, rstN) \
    always_ff @(posedge clk or negedge rstN) begin \
        if (!rstN) q <= rstVal; \
        else       q <= d; \
    end

`define RVC_DFF_RST_EN(q, d, en, rstVal, clk, rstN) \
    always_ff @(posedge clk or negedge rstN) begin \
        if (!rstN)   q <= rstVal; \
        else if (en) q <= d; \
    end

`endif

// File: rtl/rvc_mem_arb.sv
// Two-requester arbiter in front of the shared single-port D_MEM.
//
// Core has priority over Ext, except when Ext has lost STARVE_MAX cycles in
// a row, in which case Ext is forced through. One access per cycle, driven
// combinationally to the memory in the grant cycle; the response (read data
// or a write acknowledge with zero data) pulses to the owner one cycle later.
//
// Ports:
//   Clock, Rst                    : clock, asynchronous active-low reset
//   CoreReq*/CoreAddr/... (in)    : Core request (valid, addr, data, byte en, write)
//   CoreReqReady (out)            : Core request accepted this cycle
//   CoreRspValid/CoreRdData (out) : Core response strobe and read data
//   Ext*                          : same set for the external loader/debug port
//   Mem* (out)                    : address, write data and strobes to D_MEM
//   MemRdData (in)                : D_MEM read data, one cycle after MemRdEn
`ifndef RVC_ASAP_MACROS_SV
`include "rvc_asap_macros.sv"
`endif

module rvc_mem_arb
    import rvc_asap_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        Clock,
    input  logic        Rst,

    input  logic        CoreReqValid,
    output logic        CoreReqReady,
    input  logic [31:0] CoreAddr,
    input  logic [31:0] CoreWrData,
    input  logic [3:0]  CoreByteEn,
    input  logic        CoreWrEn,
    output logic        CoreRspValid,
    output logic [31:0] CoreRdData,

    input  logic        ExtReqValid,
    output logic        ExtReqReady,
    input  logic [31:0] ExtAddr,
    input  logic [31:0] ExtWrData,
    input  logic [3:0]  ExtByteEn,
    input  logic        ExtWrEn,
    output logic        ExtRspValid,
    output logic [31:0] ExtRdData,

    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    output logic [3:0]  MemByteEn,
    output logic        MemWrEn,
    output logic        MemRdEn,
    input  logic [31:0] MemRdData
);

    logic    forceExt;
    logic    grantCore;
    logic    grantExt;
    logic    grantAny;
    logic    grantWr;
    t_arb_id grantId;

    logic    rspPend;
    logic    rspWr;
    t_arb_id rspOwner;

    rvc_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) uStarve (
        .Clock     (Clock),
        .Rst       (Rst),
        .extValid  (ExtReqValid),
        .extGrant  (grantExt),
        .coreGrant (grantCore),
        .forceExt  (forceExt)
    );

    // Ready is qualified by Rst so nothing is accepted while reset is held.
    // The two grants are mutually exclusive: Core needs !forceExt, Ext needs
    // forceExt or an idle Core.
    assign CoreReqReady = Rst && !forceExt;
    assign ExtReqReady  = Rst && (forceExt || !CoreReqValid);

    assign grantCore = CoreReqValid && CoreReqReady;
    assign grantExt  = ExtReqValid  && ExtReqReady;
    assign grantAny  = grantCore || grantExt;
    assign grantId   = grantExt ? EXT : CORE;
    assign grantWr   = grantExt ? ExtWrEn : CoreWrEn;

    assign MemAddr   = grantExt ? ExtAddr   : CoreAddr;
    assign MemWrData = grantExt ? ExtWrData : CoreWrData;
    assign MemByteEn = grantAny ? (grantExt ? ExtByteEn : CoreByteEn) : '0;
    assign MemWrEn   = grantAny && grantWr;
    assign MemRdEn   = grantAny && !grantWr;

    // Response tracking: the owner and kind of the access issued last cycle.
    // The async reset drops any response still in flight.
    `RVC_DFF_RST(rspPend, grantAny, 1'b0, Clock, Rst)
    `RVC_DFF_RST_EN(rspOwner, grantId, grantAny, CORE, Clock, Rst)
    `RVC_DFF_RST_EN(rspWr, grantWr, grantAny, 1'b0, Clock, Rst)

    assign CoreRspValid = rspPend && (rspOwner == CORE);
    assign ExtRspValid  = rspPend && (rspOwner == EXT);

    // Write acknowledges carry zero data; read data is passed straight
    // through from the memory in the response cycle.
    assign CoreRdData = (CoreRspValid && !rspWr) ? MemRdData : '0;
    assign ExtRdData  = (ExtRspValid  && !rspWr) ? MemRdData : '0;

endmodule

// File: doc/rvc_mem_arb.md
RVC_MEM_ARB -- requirements
Module: rvc_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive lost arbitration cycles after which Ext is force-granted (legal 1..15).
REQ-002 Clock  in  1  single clock; all state on rising edge.
REQ-003 Rst  in  1  reset; asynchronous, active-low.
REQ-004 CoreReqValid  in  1  core request pending.
REQ-005 CoreReqReady  out  1  core request accepted this cycle.
REQ-006 CoreAddr/CoreWrData  in  32/32  core word address, write data.
REQ-007 CoreByteEn/CoreWrEn  in  4/1  core byte enables, 1=write 0=read.
REQ-008 CoreRspValid/CoreRdData  out  1/32  core response strobe, read data.
REQ-009 ExtReqValid, ExtReqReady, ExtAddr, ExtWrData, ExtByteEn, ExtWrEn, ExtRspValid, ExtRdData  same widths/meaning as the Core set, for the external loader/debug requester.
REQ-010 MemAddr/MemWrData  out  32/32  to shared single-port D_MEM.
REQ-011 MemByteEn/MemWrEn/MemRdEn  out  4/1/1  memory strobes.
REQ-012 MemRdData  in  32  memory read data, valid exactly 1 cycle after MemRdEn.

Function
REQ-013 At most one request SHALL be granted per cycle; a request transfers when ReqValid && ReqReady in the same cycle.
REQ-014 Ready SHALL be combinational from Valid and arbitration state; Ready to a requester with Valid=0 is don't-care but SHALL not issue a memory access.
REQ-015 Default priority: Core over Ext.
REQ-016 StarveCnt (4 bits) SHALL increment each cycle Ext is valid and Core is granted; clear on any Ext grant or when ExtReqValid=0.
REQ-017 When StarveCnt == STARVE_MAX and ExtReqValid=1, Ext SHALL be granted regardless of Core; CoreReqReady=0 that cycle.
REQ-018 Granted request SHALL drive Mem* combinationally in the grant cycle; MemWrEn=grant&&WrEn, MemRdEn=grant&&!WrEn; no grant -> MemWrEn=MemRdEn=0, MemByteEn=0.
REQ-019 RspOwner/RspPend registers SHALL capture grant id and validity; one cycle after any granted access (read or write), exactly one RspValid SHALL pulse for the owner.
REQ-020 RdData SHALL equal MemRdData in the RspValid cycle for reads; for writes RdData SHALL be 0.
REQ-021 Back-to-back grants every cycle SHALL be supported (throughput 1 access/cycle, latency 1).
REQ-022 Owner switch between consecutive cycles SHALL route each response correctly with no bubble.
REQ-023 CoreRdData/ExtRdData SHALL be 0 when their RspValid=0.
REQ-024 Simultaneous starvation expiry and Core write SHALL stall the Core write; Core data is held by the requester per valid/ready.

Reset
REQ-025 Rst low SHALL immediately force: StarveCnt=0, RspPend=0, RspOwner=Core, all RspValid=0, all Ready=0, MemWrEn=MemRdEn=0.
REQ-026 Reset asserted mid-access SHALL drop the pending response; no RspValid after reset release.
REQ-027 First grant SHALL be possible in the first Clock edge after Rst deasserts.

Structure
REQ-028 rvc_asap_pkg SHALL hold typedef t_arb_id (CORE=1'b0, EXT=1'b1) and localparam STARVE_CNT_W=4.
REQ-029 Flops SHALL use the shared async-reset flop macros from rvc_asap_macros.sv.
REQ-030 One sub-module rvc_arb_starve (counter + force-grant compare) SHALL be instantiated; rest is flat.

Verification
REQ-031 Core read 0x100 alone -> cycle0 MemRdEn=1 MemAddr=0x100; cycle1 CoreRspValid=1, CoreRdData=mem[0x100], ExtRspValid=0.
REQ-032 Core and Ext valid every cycle, STARVE_MAX=4 -> Core granted 4 cycles, Ext granted cycle 5, StarveCnt back to 0, repeat pattern.
REQ-033 Alternating Ext write 0xDEADBEEF@0x40 then Core read 0x40 next cycle -> Core read returns 0xDEADBEEF, both RspValid pulses exactly once.
REQ-034 Ext write ByteEn=4'b0010 -> only byte1 modified, ExtRspValid=1 next cycle with ExtRdData=0.
REQ-035 Rst low one cycle after a granted read -> no RspValid afterward; all outputs at reset values while Rst low.
REQ-036 Ext drops valid after 3 losses -> StarveCnt clears; later Ext request waits a full 4 Core grants again.
